// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch and branch-resolution front end of the 8-bit CPU. Reads the 128x8
// synchronous program ROM, absorbs its one-cycle read latency, assembles one-
// and two-byte instructions and hands non-branch instructions to execute over
// a valid/ready handshake. The nine branches (0x20-0x28) are resolved here
// against the {N,Z,V,C} flags and are never issued. Illegal opcodes and any
// attempt to address past the ROM end park the unit in a sticky fault state
// that only reset leaves.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   rom_address   registered ROM address
//   rom_data      ROM data_out, valid the cycle after an address is captured
//   flags         {N,Z,V,C} from execute, sampled only when resolving a branch
//   instr_valid   opcode/operand hold a complete instruction
//   instr_ready   execute accepts the instruction
//   opcode        registered opcode
//   operand       registered second byte, 0 for one-byte instructions
//   pc_out        address of the next byte to fetch
//   branch_taken  one-cycle pulse after a branch loads the PC
//   fault         sticky error flag
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int ROM_DEPTH = 128
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] rom_address,
    input  logic [7:0] rom_data,
    input  logic [3:0] flags,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] opcode,
    output logic [7:0] operand,
    output logic [7:0] pc_out,
    output logic       branch_taken,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_OP_REQ,
        S_OP_CAP,
        S_ARG_REQ,
        S_ARG_CAP,
        S_ISSUE,
        S_BRANCH,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        C_ONE,
        C_TWO,
        C_BRANCH,
        C_ILLEGAL
    } op_class_t;

    state_t     state, state_d;
    logic [7:0] pc, pc_d, pc_inc;
    logic [7:0] opcode_d, operand_d, rom_address_d;
    logic       instr_valid_d, branch_taken_d, fault_d;
    op_class_t  cap_class;
    logic       cond_true;

    function automatic op_class_t classify(input logic [7:0] op);
        if (op >= 8'h42 && op <= 8'h4C)
            return C_ONE;
        else if ((op >= 8'h86 && op <= 8'h89) || op == 8'h96 || op == 8'h97)
            return C_TWO;
        else if (op >= 8'h20 && op <= 8'h28)
            return C_BRANCH;
        else
            return C_ILLEGAL;
    endfunction

    // Branch condition selected by the low nibble of a branch opcode.
    // f = {N,Z,V,C}.
    function automatic logic branch_cond(input logic [3:0] sel, input logic [3:0] f);
        case (sel)
            4'h0:    return 1'b1;   // BRA
            4'h1:    return  f[3];  // BMI
            4'h2:    return !f[3];  // BPL
            4'h3:    return  f[2];  // BEQ
            4'h4:    return !f[2];  // BNE
            4'h5:    return  f[1];  // BVS
            4'h6:    return !f[1];  // BVC
            4'h7:    return  f[0];  // BCS
            4'h8:    return !f[0];  // BCC
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic addr_ok(input logic [7:0] a);
        return int'({1'b0, a}) < ROM_DEPTH;
    endfunction

    assign pc_out    = pc;
    assign pc_inc    = pc + 8'd1;
    assign cap_class = classify(rom_data);
    assign cond_true = branch_cond(opcode[3:0], flags);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (!reset)
            state <= S_OP_REQ;
        else
            state <= state_d;
    end

    // Next values of pc, opcode and operand. These depend only on the
    // current state, so the next-state logic below can consult pc_d to
    // veto out-of-range address loads.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // block leaves it unassigned, which would infer a latch.
        pc_d      = pc;
        opcode_d  = opcode;
        operand_d = operand;
        case (state)
            S_OP_CAP: begin
                opcode_d = rom_data;
                pc_d     = pc_inc;
                if (cap_class == C_ONE)
                    operand_d = 8'h00;
            end
            S_ARG_CAP: begin
                operand_d = rom_data;
                pc_d      = pc_inc;
            end
            S_BRANCH: begin
                if (cond_true)
                    pc_d = operand;
            end
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            S_OP_REQ:  state_d = S_OP_CAP;
            S_OP_CAP: begin
                case (cap_class)
                    C_ONE:           state_d = S_ISSUE;
                    C_TWO, C_BRANCH: state_d = S_ARG_REQ;
                    default:         state_d = S_FAULT;
                endcase
            end
            S_ARG_REQ: state_d = S_ARG_CAP;
            S_ARG_CAP: state_d = (classify(opcode) == C_BRANCH) ? S_BRANCH : S_ISSUE;
            S_ISSUE: begin
                if (instr_ready)
                    state_d = S_OP_REQ;
            end
            S_BRANCH:  state_d = S_OP_REQ;
            default:   state_d = S_FAULT;
        endcase
        // Entering a *_REQ state is the only time rom_address is reloaded
        // (with pc_d). An address past the ROM end diverts to FAULT instead,
        // leaving the offending value visible on pc_out.
        if ((state_d == S_OP_REQ || state_d == S_ARG_REQ) && !addr_ok(pc_d))
            state_d = S_FAULT;
    end

    // Output logic: next values of the registered outputs, derived from the
    // state being entered so every output is glitch-free.
    always_comb begin
        rom_address_d = rom_address;
        if (state_d == S_OP_REQ || state_d == S_ARG_REQ)
            rom_address_d = pc_d;
        instr_valid_d  = (state_d == S_ISSUE);
        branch_taken_d = (state == S_BRANCH) && cond_true && (state_d == S_OP_REQ);
        fault_d        = (state_d == S_FAULT);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= 8'h00;
            opcode       <= 8'h00;
            operand      <= 8'h00;
            rom_address  <= 8'h00;
            instr_valid  <= 1'b0;
            branch_taken <= 1'b0;
            fault        <= 1'b0;
        end else begin
            pc           <= pc_d;
            opcode       <= opcode_d;
            operand      <= operand_d;
            rom_address  <= rom_address_d;
            instr_valid  <= instr_valid_d;
            branch_taken <= branch_taken_d;
            fault        <= fault_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. A behavioural ROM feeds the DUT;
// an instruction-level interpreter of the program predicts the observable
// event stream (issued instructions, taken branches, fault) together with the
// number of cycles each event should take. Directed programs cover the
// straight-line, backpressure, BVC loop, flag sweep, fault and mid-branch
// reset scenarios; random programs with random backpressure cover the rest.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int ROM_DEPTH = 128;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rom_address;
    logic [7:0] rom_data;
    logic [3:0] flags;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic [7:0] pc_out;
    logic       branch_taken;
    logic       fault;

    logic [7:0] rom [256];

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum int {EV_ISSUE, EV_TAKEN, EV_FAULT} ev_kind_t;

    typedef struct {
        ev_kind_t   kind;
        logic [7:0] op;
        logic [7:0] opd;
        logic [7:0] addr;   // rom_address while the event is visible
        logic [7:0] pc;     // pc_out while the event is visible
        int         gap;    // cycles since the previous observable event ended
    } ev_t;

    ev_t exp_q[$];

    instr_fetch_unit #(.ROM_DEPTH(ROM_DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .rom_address  (rom_address),
        .rom_data     (rom_data),
        .flags        (flags),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .operand      (operand),
        .pc_out       (pc_out),
        .branch_taken (branch_taken),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: address captured at the edge, data valid after it.
    always @(posedge clk) rom_data <= rom[rom_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    // Reference model: walks the program one instruction at a time.
    // -----------------------------------------------------------------------
    function automatic bit model_taken(input int op, input logic [3:0] f);
        int idx;
        if (op == 'h20) return 1'b1;
        idx = op - 'h21;                      // pairs: (N,!N) (Z,!Z) (V,!V) (C,!C)
        return f[3 - idx / 2] ^ idx[0];
    endfunction

    function automatic bit is_two_byte(input int op);
        return (op >= 'h86 && op <= 'h89) || op == 'h96 || op == 'h97;
    endfunction

    task automatic push_ev(input ev_kind_t k, input int op, input int opd,
                           input int addr, input int pc, input int gap);
        ev_t e;
        e.kind = k;
        e.op   = 8'(op);
        e.opd  = 8'(opd);
        e.addr = 8'(addr);
        e.pc   = 8'(pc);
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic build_model(input logic [3:0] f);
        int pc  = 0;
        int acc = 0;   // cycles spent in unobservable (not-taken) branches
        int op, tgt, nxt;
        exp_q.delete();
        for (int step = 0; step < 5000 && exp_q.size() < 300; step++) begin
            op = int'(rom[pc]);
            if (op >= 'h42 && op <= 'h4C) begin
                push_ev(EV_ISSUE, op, 0, pc, pc + 1, acc + 2);
                acc = 0;
                pc  = pc + 1;
                if (pc >= ROM_DEPTH) begin
                    push_ev(EV_FAULT, 0, 0, pc - 1, pc, 0);
                    break;
                end
            end else if (is_two_byte(op) || (op >= 'h20 && op <= 'h28)) begin
                if (pc + 1 >= ROM_DEPTH) begin
                    push_ev(EV_FAULT, 0, 0, pc, pc + 1, acc + 2);
                    break;
                end
                if (is_two_byte(op)) begin
                    push_ev(EV_ISSUE, op, int'(rom[pc + 1]), pc + 1, pc + 2, acc + 4);
                    acc = 0;
                    pc  = pc + 2;
                    if (pc >= ROM_DEPTH) begin
                        push_ev(EV_FAULT, 0, 0, pc - 1, pc, 0);
                        break;
                    end
                end else begin
                    tgt = int'(rom[pc + 1]);
                    nxt = model_taken(op, f) ? tgt : pc + 2;
                    if (nxt >= ROM_DEPTH) begin
                        push_ev(EV_FAULT, 0, 0, pc + 1, nxt, acc + 5);
                        break;
                    end
                    if (model_taken(op, f)) begin
                        push_ev(EV_TAKEN, 0, 0, tgt, tgt, acc + 5);
                        acc = 0;
                    end else begin
                        acc = acc + 5;
                    end
                    pc = nxt;
                end
            end else begin
                push_ev(EV_FAULT, 0, 0, pc, pc + 1, acc + 2);
                break;
            end
        end
    endtask

    // Pop the next predicted event and compare its kind and timing.
    task automatic expect_event(input ev_kind_t obs, input int elapsed,
                                output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{EV_FAULT, 8'h00, 8'h00, 8'h00, 8'h00, 0};
        if (exp_q.size() == 0) begin
            check("event_queue_empty", 32'(obs), 32'hFFFF_FFFF);
            return;
        end
        e  = exp_q.pop_front();
        ok = 1'b1;
        check("event_kind", 32'(obs), 32'(e.kind));
        check("event_cycles", 32'(elapsed), 32'(e.gap));
    endtask

    // Reset, then run the loaded program with constant flags and random
    // backpressure, comparing every observable event against the model.
    task automatic run_program(input logic [3:0] f, input int ready_pct, input int max_cycles);
        ev_t cur;
        bit  ok;
        bit  in_issue = 1'b0;
        bit  done     = 1'b0;
        int  prev_end = 0;
        int  cyc      = 0;
        build_model(f);
        flags       = f;
        instr_ready = 1'b0;
        do_reset();
        while (!done && cyc < max_cycles) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (rom_address >= 8'h80)
                check("rom_address_range", 32'(rom_address), 32'h7F);
            if (fault) begin
                expect_event(EV_FAULT, cyc - prev_end, cur, ok);
                if (ok) begin
                    check("fault_rom_address", 32'(rom_address), 32'(cur.addr));
                    check("fault_pc_out", 32'(pc_out), 32'(cur.pc));
                end
                check("fault_instr_valid", 32'(instr_valid), 0);
                done = 1'b1;
            end else if (branch_taken) begin
                expect_event(EV_TAKEN, cyc - prev_end, cur, ok);
                if (ok) begin
                    check("taken_rom_address", 32'(rom_address), 32'(cur.addr));
                    check("taken_pc_out", 32'(pc_out), 32'(cur.pc));
                end else begin
                    done = 1'b1;
                end
                prev_end = cyc;
            end else if (instr_valid) begin
                if (!in_issue) begin
                    expect_event(EV_ISSUE, cyc - prev_end, cur, ok);
                    if (!ok) done = 1'b1;
                    in_issue = 1'b1;
                end
                // Checked every cycle, so a stall must hold these steady.
                check("issue_opcode", 32'(opcode), 32'(cur.op));
                check("issue_operand", 32'(operand), 32'(cur.opd));
                check("issue_rom_address", 32'(rom_address), 32'(cur.addr));
                check("issue_pc_out", 32'(pc_out), 32'(cur.pc));
            end else if (exp_q.size() > 0 && (cyc - prev_end) > exp_q[0].gap) begin
                check("event_late", 32'(cyc - prev_end), 32'(exp_q[0].gap));
                done = 1'b1;
            end
            instr_ready = ($urandom_range(99, 0) < ready_pct);
            if (instr_valid && instr_ready) begin
                in_issue = 1'b0;
                prev_end = cyc + 1;
            end
        end
    endtask

    task automatic load_random_program();
        logic [7:0] two_ops [6] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97};
        int n = $urandom_range(16, 4);
        int addr[$];
        int cls[$];
        int a = 0;
        clear_rom();
        for (int i = 0; i < n; i++) begin
            cls.push_back($urandom_range(2, 0));
            addr.push_back(a);
            a += (cls[i] == 0) ? 1 : 2;
        end
        for (int i = 0; i < n; i++) begin
            case (cls[i])
                0: rom[addr[i]] = 8'(8'h42 + $urandom_range(10, 0));
                1: begin
                    rom[addr[i]]     = two_ops[$urandom_range(5, 0)];
                    rom[addr[i] + 1] = 8'($urandom);
                end
                default: begin
                    rom[addr[i]]     = 8'(8'h20 + $urandom_range(8, 0));
                    rom[addr[i] + 1] = 8'(addr[$urandom_range(n - 1, 0)]);
                end
            endcase
        end
    endtask

    initial begin
        int         seq[$];
        int         vcount;
        bit         found;
        logic [7:0] sweep_flags [2] = '{4'b0000, 4'b1111};

        reset       = 1'b0;
        flags       = 4'h0;
        instr_ready = 1'b0;
        clear_rom();

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_rom_address", 32'(rom_address), 0);
        check("reset_instr_valid", 32'(instr_valid), 0);
        check("reset_opcode", 32'(opcode), 0);
        check("reset_operand", 32'(operand), 0);
        check("reset_pc_out", 32'(pc_out), 0);
        check("reset_branch_taken", 32'(branch_taken), 0);
        check("reset_fault", 32'(fault), 0);

        // Straight-line fetch: address sequence and one valid cycle each.
        clear_rom();
        {rom[0], rom[1], rom[2], rom[3], rom[4]} = {8'h86, 8'h00, 8'h88, 8'h01, 8'h42};
        instr_ready = 1'b1;
        do_reset();
        seq.push_back(int'(rom_address));
        vcount = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (int'(rom_address) != seq[$]) seq.push_back(int'(rom_address));
            if (instr_valid) vcount++;
        end
        check("addr_seq_length_ok", 32'(seq.size() >= 5), 1);
        for (int i = 0; i < 5 && i < seq.size(); i++)
            check("addr_seq", 32'(seq[i]), 32'(i));
        check("valid_cycles", 32'(vcount), 3);
        run_program(4'h0, 100, 40);
        run_program(4'h0, 50, 80);

        // Backpressure during the first ISSUE.
        instr_ready = 1'b0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = instr_valid;
        end
        check("bp_reached_issue", 32'(found), 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_instr_valid", 32'(instr_valid), 1);
            check("bp_opcode", 32'(opcode), 32'h86);
            check("bp_operand", 32'(operand), 32'h00);
            check("bp_rom_address", 32'(rom_address), 32'h01);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(instr_valid), 0);
        check("bp_release_rom_address", 32'(rom_address), 32'h02);

        // BVC loop, V clear (taken) then V set (not taken, falls to 8).
        clear_rom();
        {rom[0], rom[1], rom[2], rom[3]} = {8'h86, 8'h00, 8'h88, 8'h01};
        {rom[4], rom[5], rom[6], rom[7]} = {8'h42, 8'h42, 8'h26, 8'h04};
        run_program(4'b0000, 80, 200);
        run_program(4'b0010, 80, 100);

        // Flag sweep over all nine branches, target 0x10.
        for (int op = 'h20; op <= 'h28; op++) begin
            for (int k = 0; k < 2; k++) begin
                clear_rom();
                rom[0]     = 8'(op);
                rom[1]     = 8'h10;
                rom[2]     = 8'h43;
                rom[8'h10] = 8'h42;
                run_program(sweep_flags[k][3:0], 100, 40);
            end
        end

        // Faults: illegal opcode, branch past the ROM end, one-byte at 127.
        clear_rom();
        run_program(4'h0, 100, 20);
        clear_rom();
        {rom[0], rom[1]} = {8'h20, 8'h80};
        run_program(4'h0, 100, 20);
        clear_rom();
        {rom[0], rom[1], rom[127]} = {8'h20, 8'h7F, 8'h42};
        run_program(4'h0, 100, 30);

        // Reset asserted in the ARG_CAP cycle of a BRA.
        clear_rom();
        {rom[0], rom[1], rom[2], rom[3], rom[4]} = {8'h42, 8'h86, 8'h05, 8'h20, 8'h00};
        instr_ready = 1'b1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = (rom_address == 8'h04);
        end
        check("mid_branch_reached", 32'(found), 1);
        @(posedge clk);
        #2;
        check("pre_reset_opcode", 32'(opcode), 32'h20);
        reset = 1'b0;
        #1;
        check("async_rom_address", 32'(rom_address), 0);
        check("async_instr_valid", 32'(instr_valid), 0);
        check("async_opcode", 32'(opcode), 0);
        check("async_operand", 32'(operand), 0);
        check("async_pc_out", 32'(pc_out), 0);
        check("async_branch_taken", 32'(branch_taken), 0);
        check("async_fault", 32'(fault), 0);
        run_program(4'h0, 70, 200);

        // Random programs, random flags, random backpressure.
        for (int r = 0; r < 20; r++) begin
            load_random_program();
            run_program(4'($urandom), $urandom_range(100, 30), 300);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch and branch-resolution front end of the 8-bit CPU. Acts as the reader for the 128x8 synchronous program ROM: drives the ROM address, absorbs the ROM's one-cycle read latency, and assembles one- or two-byte instructions. It hands non-branch instructions to the execute stage over a valid/ready handshake and resolves the nine conditional and unconditional branches internally against the N/Z/V/C flags.

## Interface
- `ROM_DEPTH`, default 128: number of valid ROM addresses (0..ROM_DEPTH-1).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rom_address`  out  8  registered ROM address.
- `rom_data`  in  8  ROM `data_out`. Valid one edge after `rom_address` has been held across a rising edge.
- `flags`  in  4  {N,Z,V,C} from the execute stage.
- `instr_valid`  out  1  `opcode`/`operand` hold a complete instruction.
- `instr_ready`  in  1  execute stage accepts the instruction.
- `opcode`  out  8  registered opcode.
- `operand`  out  8  registered second byte. 0 for one-byte instructions.
- `pc_out`  out  8  address of the next byte to fetch.
- `branch_taken`  out  1  one-cycle pulse when a branch loads the PC.
- `fault`  out  1  sticky error: illegal opcode or address ≥ ROM_DEPTH.

## Operation
- **Reset:** all outputs 0, pc=0, state=OP_REQ.
- **Opcode classes:**
  - One-byte: 0x42–0x4C.
  - Two-byte data: 0x86–0x89, 0x96, 0x97.
  - Branch: 0x20–0x28.
  - Any other value is illegal.
- **State machine:**
  - **OP_REQ:** `rom_address`=pc. Always → OP_CAP.
  - **OP_CAP:** `opcode`<=`rom_data`, pc<=pc+1.
    - One-byte: `operand`<=0, → ISSUE.
    - Two-byte or branch: `rom_address`<=pc+1, → ARG_REQ.
    - Illegal: → FAULT.
  - **ARG_REQ:** → ARG_CAP.
  - **ARG_CAP:** `operand`<=`rom_data`, pc<=pc+1. Branch → BRANCH, otherwise → ISSUE.
  - **ISSUE:** `instr_valid`=1.
    - `opcode` and `operand` stay stable until accepted.
    - When `instr_ready`=1 at the edge: `rom_address`<=pc, → OP_REQ.
  - **BRANCH:** `flags` sampled at this edge. Conditions:
    - BRA: always taken.
    - BMI: N. BPL: !N.
    - BEQ: Z. BNE: !Z.
    - BVS: V. BVC: !V.
    - BCS: C. BCC: !C.
    - Taken: pc<=`operand`, `rom_address`<=`operand`, `branch_taken`=1 for the following cycle.
    - Not taken: pc unchanged, `rom_address`<=pc.
    - → OP_REQ.
  - **FAULT:** `fault`=1, `instr_valid`=0, `rom_address` frozen. Exit only by reset.
- **Address check:** any value about to load into `rom_address` that is ≥ ROM_DEPTH goes to FAULT instead, with the offending value left on `pc_out`.
  - Examples: pc+1 from 127; a branch target of 0x80 or above.
- **Width:** pc is 8-bit. Overflow past 255 cannot occur because the limit check at 128 triggers first.
- **Flags contract:** execute must present flags updated by the last accepted instruction no later than the BRANCH cycle. Flags are ignored in all other states.

## Timing
- **ROM latency:** address held in a *_REQ cycle is captured by the ROM at that edge. Data is consumed in the *_CAP cycle at the next edge.
- **Minimum cycles per instruction:**
  - One-byte: 3 (OP_REQ, OP_CAP, ISSUE with `instr_ready`=1).
  - Two-byte data: 5.
  - Branch: 5, taken or not; nothing is issued to execute.
- **Stall:** `instr_ready`=0 in ISSUE holds every output unchanged indefinitely. No ROM reads occur during the stall.
- **Registered outputs:** `instr_valid` rises on the edge entering ISSUE and falls on the edge where the handshake completes.
- **Reset mid-operation:** reset asserted in any state clears outputs immediately (asynchronous). The first OP_REQ with address 0 follows the first edge after release.
- **Simultaneous events:** a branch whose target equals its own address is legal and loops, re-fetching the branch every 5 cycles.

## Test plan
- **Straight-line fetch:** ROM = 86 00 88 01 42, `instr_ready`=1.
  - Issues (86,00), (88,01), (42,00).
  - `instr_valid` high one cycle each.
  - `rom_address` sequence: 0,1,2,3,4.
- **Backpressure:** hold `instr_ready`=0 for 10 cycles during the first ISSUE.
  - `opcode`=86, `operand`=00 and `rom_address`=1 stay constant.
  - Fetch resumes the cycle after `instr_ready`=1.
- **BVC loop:** ROM = 86 00 88 01 42 42 26 04.
  - With V=0: `branch_taken` pulses, next `rom_address`=4, 42 re-issued.
  - With V=1: not taken, `rom_address`=8.
- **Flag sweep:** for each of 0x20–0x28, try flags {N,Z,V,C}=0000 and 1111.
  - Taken/not-taken must match the condition table, with target 0x10.
- **Faults:**
  - Opcode 0xFF at address 0 gives `fault`=1 after 2 cycles, with `instr_valid` never asserted.
  - BRA 0x80 gives `fault`=1 and `rom_address` never driven to 0x80.
  - A one-byte opcode at address 127 gives `fault`=1.
- **Reset mid-branch:** assert reset in ARG_CAP of a BRA.
  - All outputs go to 0 immediately.
  - After release, the fetch from address 0 repeats the program exactly.
